// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and helpers for the load/store unit
package mem_pkg;

  localparam int WORD_SHIFT_DEFAULT = 3;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } mem_size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input mem_size_e size);
    return 4'd1 << size;
  endfunction

  function automatic logic is_misaligned(input mem_size_e size, input logic [2:0] off);
    case (size)
      SIZE_H:  return off[0];
      SIZE_W:  return |off[1:0];
      SIZE_D:  return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - load lane extraction/extension and store byte merge
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [2:0]  offset,
  input  logic [63:0] sram_word,
  input  logic [63:0] store_data,
  output logic [63:0] load_data,
  output logic [63:0] merged_word
);

  logic [63:0] shifted;
  logic [63:0] inserted;
  logic [7:0]  mask_base;
  logic [7:0]  byte_mask;
  logic        sx;

  always_comb begin
    shifted = sram_word >> {offset, 3'b000};
    sx      = ~is_unsigned;
    case (mem_size_e'(size))
      SIZE_B:  load_data = {{56{sx & shifted[7]}},  shifted[7:0]};
      SIZE_H:  load_data = {{48{sx & shifted[15]}}, shifted[15:0]};
      SIZE_W:  load_data = {{32{sx & shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  // A double wraps 1<<8 to zero in 8 bits, so the mask becomes all ones.
  always_comb begin
    inserted  = store_data << {offset, 3'b000};
    mask_base = (8'd1 << size_bytes(mem_size_e'(size))) - 8'd1;
    byte_mask = mask_base << offset;
    merged_word = sram_word;
    for (int i = 0; i < 8; i++) begin
      if (byte_mask[i]) merged_word[8*i +: 8] = inserted[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - single-request load/store unit with sub-word read-modify-write
module mem_lsu
  import mem_pkg::*;
#(
  parameter int WORD_SHIFT = WORD_SHIFT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign,
  output logic        data_sram_en,
  output logic        data_sram_wen,
  output logic [63:0] data_sram_addr,
  output logic [63:0] data_sram_wdata,
  input  logic [63:0] data_sram_rdata
);

  lsu_state_e  state;
  mem_size_e   in_size;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [2:0]  r_off;
  logic [63:0] r_wdata;
  logic [63:0] load_data;
  logic [63:0] merged_word;
  logic        accept;
  logic        misalign;

  assign in_size   = mem_size_e'(req_size);
  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign misalign  = is_misaligned(in_size, req_addr[2:0]);

  lsu_lane_align u_align (
    .size        (r_size),
    .is_unsigned (r_uns),
    .offset      (r_off),
    .sram_word   (data_sram_rdata),
    .store_data  (r_wdata),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // SRAM strobes are registered on entry to the state that owns them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      r_size          <= 2'd0;
      r_uns           <= 1'b0;
      r_off           <= 3'd0;
      r_wdata         <= 64'd0;
      resp_valid      <= 1'b0;
      resp_rdata      <= 64'd0;
      resp_misalign   <= 1'b0;
      data_sram_en    <= 1'b0;
      data_sram_wen   <= 1'b0;
      data_sram_addr  <= 64'd0;
      data_sram_wdata <= 64'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_off   <= req_addr[2:0];
            r_wdata <= req_wdata;
            if (misalign) begin
              state         <= ST_RESP;
              resp_valid    <= 1'b1;
              resp_misalign <= 1'b1;
              resp_rdata    <= 64'd0;
            end else begin
              data_sram_en   <= 1'b1;
              data_sram_addr <= req_addr >> WORD_SHIFT;
              if (!req_wen) begin
                state <= ST_LOAD;
              end else if (in_size == SIZE_D) begin
                state           <= ST_STORE;
                data_sram_wen   <= 1'b1;
                data_sram_wdata <= req_wdata;
              end else begin
                state <= ST_RMW_RD;
              end
            end
          end
        end
        ST_LOAD: begin
          resp_rdata     <= load_data;
          resp_valid     <= 1'b1;
          data_sram_en   <= 1'b0;
          data_sram_addr <= 64'd0;
          state          <= ST_RESP;
        end
        ST_RMW_RD: begin
          data_sram_wen   <= 1'b1;
          data_sram_wdata <= merged_word;
          state           <= ST_RMW_WR;
        end
        ST_STORE, ST_RMW_WR: begin
          resp_valid      <= 1'b1;
          resp_rdata      <= 64'd0;
          data_sram_en    <= 1'b0;
          data_sram_wen   <= 1'b0;
          data_sram_addr  <= 64'd0;
          data_sram_wdata <= 64'd0;
          state           <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid    <= 1'b0;
            resp_misalign <= 1'b0;
            resp_rdata    <= 64'd0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter WORD_SHIFT, default 3, meaning log2 of SRAM word bytes (byte address to word index shift).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  memory request present.
REQ-005 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-006 SHALL have port req_wen  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  0 = byte, 1 = half, 2 = word(32), 3 = double(64).
REQ-008 SHALL have port req_unsigned  input  1  load zero-extends when high, sign-extends when low.
REQ-009 SHALL have port req_addr  input  64  byte address.
REQ-010 SHALL have port req_wdata  input  64  store data, right-aligned in bits [8*bytes-1:0].
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  consumer takes response.
REQ-013 SHALL have port resp_rdata  output  64  extended load data; 0 for stores and faults.
REQ-014 SHALL have port resp_misalign  output  1  request was misaligned; no SRAM access made.
REQ-015 SHALL have ports data_sram_en (out 1), data_sram_wen (out 1), data_sram_addr (out 64, word index), data_sram_wdata (out 64), data_sram_rdata (in 64, combinational read of data_sram_addr, gated by en).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; accept on req_valid&req_ready, registering wen, size, unsigned, addr, wdata.
REQ-018 SHALL treat misaligned as: half with addr[0]!=0, word with addr[1:0]!=0, double with addr[2:0]!=0; misaligned accept -> RESP with resp_misalign=1, no SRAM enable.
REQ-019 SHALL transition IDLE -> LOAD for aligned loads, -> STORE for aligned double stores, -> RMW_RD for aligned byte/half/word stores.
REQ-020 SHALL in LOAD drive en=1, wen=0, addr=req_addr>>WORD_SHIFT; capture rdata at clock end, select lane at byte offset addr[2:0], extend per size/unsigned; -> RESP.
REQ-021 SHALL in STORE drive en=1, wen=1, wdata=req_wdata; -> RESP.
REQ-022 SHALL in RMW_RD drive en=1, wen=0, capture old word; -> RMW_WR.
REQ-023 SHALL in RMW_WR drive en=1, wen=1, wdata = old word with bytes [offset, offset+size_bytes) replaced by low store bytes; all other bytes unchanged; -> RESP.
REQ-024 SHALL in RESP hold resp_valid=1 and stable resp_rdata/resp_misalign until resp_ready=1, then -> IDLE (no same-cycle acceptance of next request).
REQ-025 SHALL drive en=0, wen=0, addr=0, wdata=0 in IDLE and RESP; wen SHALL be 1 in exactly one cycle per aligned store.
REQ-026 SHALL yield latency accept-edge to resp_valid: misaligned 1 cycle, load 2, double store 2, sub-word store 3.

Reset
REQ-027 SHALL on reset asynchronously enter IDLE, clear all captured registers, force resp_valid=0, resp_misalign=0, resp_rdata=0, data_sram_* outputs 0.
REQ-028 SHALL abandon any in-flight request on reset; a store reset before RMW_WR SHALL leave SRAM unmodified.

Structure
REQ-029 SHALL place size encodings, FSM state encoding and WORD_SHIFT default in shared package mem_pkg.
REQ-030 SHALL use one sub-module, lsu_lane_align, purely combinational: load lane extraction/extension and store byte-merge.

Verification
REQ-031 Load byte signed, word 0x0000_0000_0000_80FF at index 2, addr 0x10, size 0 -> resp_rdata 0xFFFF_FFFF_FFFF_FFFF after 2 cycles.
REQ-032 Store half 0xBEEF at addr 0x0A over 0x1111_1111_1111_1111 -> word index 1 reads 0x1111_1111_BEEF_1111, wen pulsed once.
REQ-033 Load word at addr 0x06 -> resp_misalign=1, rdata 0, en never asserted, resp after 1 cycle.
REQ-034 Store double 0x0123_4567_89AB_CDEF at addr 0x18 with resp_ready low 5 cycles -> resp_valid held, req_ready 0 throughout, word index 3 updated.
REQ-035 Assert reset in RMW_RD of byte store -> all outputs 0 immediately, SRAM word unchanged, next request served normally.
